// File: rtl/abacus_perf_pkg.sv
// Shared constants for the ABACUS performance counter bank: event map,
// register addresses and CTRL bit positions.
package abacus_perf_pkg;

    localparam int unsigned NUM_EVENTS = 17;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned DATA_W     = 32;

    typedef enum logic [4:0] {
        EV_CYCLE,
        EV_ISSUED,
        EV_ICACHE_REQUEST,
        EV_ICACHE_MISS,
        EV_ICACHE_FILL,
        EV_DCACHE_REQUEST,
        EV_DCACHE_HIT,
        EV_DCACHE_FILL,
        EV_BRANCH_MISPRED,
        EV_RAS_MISPRED,
        EV_NO_INSTRUCTION,
        EV_NO_ID,
        EV_FLUSH,
        EV_UNIT_BUSY,
        EV_OPERANDS_NOT_READY,
        EV_HOLD,
        EV_MULTI_SOURCE
    } event_idx_e;

    localparam logic [ADDR_W-1:0] CTRL_ADDR   = 6'h00;
    localparam logic [ADDR_W-1:0] STATUS_ADDR = 6'h01;
    localparam logic [ADDR_W-1:0] ID_ADDR     = 6'h02;
    localparam logic [ADDR_W-1:0] SHADOW_BASE = 6'h20;

    localparam int unsigned CTRL_ENABLE_BIT   = 0;
    localparam int unsigned CTRL_CLEAR_BIT    = 1;
    localparam int unsigned CTRL_SNAPSHOT_BIT = 2;

    localparam logic [DATA_W-1:0] ID_VALUE = 32'hABAC_0001;

endpackage

// File: rtl/abacus_counter.sv
// One event counter with a snapshot shadow register and a wrap pulse.
module abacus_counter #(
    parameter int unsigned COUNTER_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clear,
    input  logic                 snapshot,
    output logic [COUNTER_W-1:0] live,
    output logic [COUNTER_W-1:0] shadow,
    output logic                 wrap_c
);

    logic [COUNTER_W-1:0] live_q, live_d;
    logic [COUNTER_W-1:0] shadow_q, shadow_d;

    // Shadow always captures the pre-clear, pre-increment value; clear beats increment.
    always_comb begin
        live_d   = live_q;
        shadow_d = shadow_q;
        wrap_c   = 1'b0;
        if (snapshot) begin
            shadow_d = live_q;
        end
        if (clear) begin
            live_d = '0;
        end else if (inc) begin
            live_d = live_q + COUNTER_W'(1);
            wrap_c = &live_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            shadow_q <= '0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

    assign live   = live_q;
    assign shadow = shadow_q;

endmodule

// File: rtl/abacus_perf_counters.sv
// Wishbone-readable bank of ABACUS profiling event counters with atomic
// snapshot into shadow registers and sticky per-counter overflow flags.
module abacus_perf_counters
    import abacus_perf_pkg::*;
#(
    parameter int unsigned COUNTER_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        abacus_instruction_issued,
    input  logic        abacus_icache_request,
    input  logic        abacus_icache_miss,
    input  logic        abacus_icache_line_fill_in_progress,
    input  logic        abacus_dcache_request,
    input  logic        abacus_dcache_hit,
    input  logic        abacus_dcache_line_fill_in_progress,
    input  logic        abacus_branch_misprediction,
    input  logic        abacus_ras_misprediction,
    input  logic        abacus_issue_no_instruction_stat,
    input  logic        abacus_issue_no_id_stat,
    input  logic        abacus_issue_flush_stat,
    input  logic        abacus_unit_busy_stat,
    input  logic        abacus_issue_operands_not_ready_stat,
    input  logic        abacus_issue_hold_stat,
    input  logic        abacus_issue_multi_source_stat,
    input  logic [5:0]  wb_adr,
    input  logic [31:0] wb_dat_w,
    input  logic [3:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    output logic [31:0] wb_dat_r,
    output logic        wb_ack,
    output logic        wb_err
);

    logic [NUM_EVENTS-1:0] ev_in_c, ev_q, ev_d;
    logic [NUM_EVENTS-1:0] ovf_q, ovf_d, wrap_c, w1c_c;
    logic                  enable_q, enable_d;
    logic                  ack_q, ack_d;
    logic [DATA_W-1:0]     dat_r_q, dat_r_d, rd_data_c;
    logic                  req_c, wr_c, ctrl_wr_c, clear_c, snap_c;
    logic [4:0]            sh_idx_c;
    logic [NUM_EVENTS-1:0][COUNTER_W-1:0] live_all, shadow_all;
    logic                  unused_c;

    always_comb begin
        ev_in_c                        = '0;
        ev_in_c[EV_CYCLE]              = 1'b1;
        ev_in_c[EV_ISSUED]             = abacus_instruction_issued;
        ev_in_c[EV_ICACHE_REQUEST]     = abacus_icache_request;
        ev_in_c[EV_ICACHE_MISS]        = abacus_icache_miss;
        ev_in_c[EV_ICACHE_FILL]        = abacus_icache_line_fill_in_progress;
        ev_in_c[EV_DCACHE_REQUEST]     = abacus_dcache_request;
        ev_in_c[EV_DCACHE_HIT]         = abacus_dcache_hit;
        ev_in_c[EV_DCACHE_FILL]        = abacus_dcache_line_fill_in_progress;
        ev_in_c[EV_BRANCH_MISPRED]     = abacus_branch_misprediction;
        ev_in_c[EV_RAS_MISPRED]        = abacus_ras_misprediction;
        ev_in_c[EV_NO_INSTRUCTION]     = abacus_issue_no_instruction_stat;
        ev_in_c[EV_NO_ID]              = abacus_issue_no_id_stat;
        ev_in_c[EV_FLUSH]              = abacus_issue_flush_stat;
        ev_in_c[EV_UNIT_BUSY]          = abacus_unit_busy_stat;
        ev_in_c[EV_OPERANDS_NOT_READY] = abacus_issue_operands_not_ready_stat;
        ev_in_c[EV_HOLD]               = abacus_issue_hold_stat;
        ev_in_c[EV_MULTI_SOURCE]       = abacus_issue_multi_source_stat;
    end

    // Read mux; shadows are zero-extended to the bus width.
    always_comb begin
        rd_data_c = '0;
        sh_idx_c  = 5'(wb_adr - SHADOW_BASE);
        if (wb_adr == CTRL_ADDR) begin
            rd_data_c = DATA_W'(enable_q);
        end else if (wb_adr == STATUS_ADDR) begin
            rd_data_c = DATA_W'(ovf_q);
        end else if (wb_adr == ID_ADDR) begin
            rd_data_c = ID_VALUE;
        end else if (wb_adr >= SHADOW_BASE && wb_adr < SHADOW_BASE + 6'(NUM_EVENTS)) begin
            rd_data_c = DATA_W'(shadow_all[sh_idx_c]);
        end
    end

    // Handshake and write decode; an outstanding ack blocks a new request.
    always_comb begin
        req_c     = wb_cyc && wb_stb && !ack_q;
        wr_c      = req_c && wb_we;
        ctrl_wr_c = wr_c && (wb_adr == CTRL_ADDR);
        clear_c   = ctrl_wr_c && wb_dat_w[CTRL_CLEAR_BIT];
        snap_c    = ctrl_wr_c && wb_dat_w[CTRL_SNAPSHOT_BIT];
        w1c_c     = (wr_c && (wb_adr == STATUS_ADDR)) ? wb_dat_w[NUM_EVENTS-1:0] : '0;
        enable_d  = ctrl_wr_c ? wb_dat_w[CTRL_ENABLE_BIT] : enable_q;
        ovf_d     = clear_c ? '0 : ((ovf_q & ~w1c_c) | wrap_c);
        ack_d     = req_c;
        dat_r_d   = (req_c && !wb_we) ? rd_data_c : '0;
        ev_d      = ev_in_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_q     <= '0;
            ovf_q    <= '0;
            enable_q <= 1'b0;
            ack_q    <= 1'b0;
            dat_r_q  <= '0;
        end else begin
            ev_q     <= ev_d;
            ovf_q    <= ovf_d;
            enable_q <= enable_d;
            ack_q    <= ack_d;
            dat_r_q  <= dat_r_d;
        end
    end

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_cnt
        abacus_counter #(.COUNTER_W(COUNTER_W)) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .inc      (enable_q && ev_q[i]),
            .clear    (clear_c),
            .snapshot (snap_c),
            .live     (live_all[i]),
            .shadow   (shadow_all[i]),
            .wrap_c   (wrap_c[i])
        );
    end

    // Byte selects, upper write bits and live values have no consumer on the bus.
    assign unused_c = ^{wb_sel, wb_dat_w[DATA_W-1:NUM_EVENTS], live_all};

    assign wb_dat_r = dat_r_q;
    assign wb_ack   = ack_q;
    assign wb_err   = 1'b0;

endmodule

// File: tb/tb_abacus_perf_counters.sv
// Self-checking bench: 32-bit and 8-bit counter banks driven in parallel
// and compared against an event-count reference model.
module tb_abacus_perf_counters;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ev;
    logic [5:0]  wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] dat_r32, dat_r8;
    logic        ack32, ack8, err32, err8;

    logic        rand_mode;
    logic [15:0] ev_force;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    abacus_perf_counters dut (
        .clk(clk), .rst(rst),
        .abacus_instruction_issued(ev[0]), .abacus_icache_request(ev[1]),
        .abacus_icache_miss(ev[2]), .abacus_icache_line_fill_in_progress(ev[3]),
        .abacus_dcache_request(ev[4]), .abacus_dcache_hit(ev[5]),
        .abacus_dcache_line_fill_in_progress(ev[6]), .abacus_branch_misprediction(ev[7]),
        .abacus_ras_misprediction(ev[8]), .abacus_issue_no_instruction_stat(ev[9]),
        .abacus_issue_no_id_stat(ev[10]), .abacus_issue_flush_stat(ev[11]),
        .abacus_unit_busy_stat(ev[12]), .abacus_issue_operands_not_ready_stat(ev[13]),
        .abacus_issue_hold_stat(ev[14]), .abacus_issue_multi_source_stat(ev[15]),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_dat_r(dat_r32), .wb_ack(ack32), .wb_err(err32)
    );

    abacus_perf_counters #(.COUNTER_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .abacus_instruction_issued(ev[0]), .abacus_icache_request(ev[1]),
        .abacus_icache_miss(ev[2]), .abacus_icache_line_fill_in_progress(ev[3]),
        .abacus_dcache_request(ev[4]), .abacus_dcache_hit(ev[5]),
        .abacus_dcache_line_fill_in_progress(ev[6]), .abacus_branch_misprediction(ev[7]),
        .abacus_ras_misprediction(ev[8]), .abacus_issue_no_instruction_stat(ev[9]),
        .abacus_issue_no_id_stat(ev[10]), .abacus_issue_flush_stat(ev[11]),
        .abacus_unit_busy_stat(ev[12]), .abacus_issue_operands_not_ready_stat(ev[13]),
        .abacus_issue_hold_stat(ev[14]), .abacus_issue_multi_source_stat(ev[15]),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_dat_r(dat_r8), .wb_ack(ack8), .wb_err(err8)
    );

    // Event stimulus, changed on the falling edge
    initial begin
        ev = '0;
        forever begin
            @(negedge clk);
            ev = rand_mode ? 16'($urandom) : ev_force;
        end
    end

    // Reference model: unbounded event totals per counter; a W-bit view is total mod 2^W.
    int unsigned edge_n = 0;
    longint      m_cnt [17];
    longint      m_sh  [17];
    bit          m_ovf32 [17];
    bit          m_ovf8  [17];
    bit          m_en, m_ack;
    bit [16:0]   m_evp;
    logic [31:0] m_exp32, m_exp8;

    function automatic logic [31:0] model_read(input logic [5:0] a, input int w);
        longint      md;
        logic [31:0] s;
        md = (w == 32) ? 64'h1_0000_0000 : 64'd256;
        s  = '0;
        if (a == 6'h00) s = {31'd0, m_en};
        else if (a == 6'h01) begin
            for (int i = 0; i < 17; i++) s[i] = (w == 32) ? m_ovf32[i] : m_ovf8[i];
        end
        else if (a == 6'h02) s = 32'hABAC0001;
        else if (a >= 6'h20 && a <= 6'h30) s = 32'(m_sh[int'(a) - 32] % md);
        return s;
    endfunction

    initial begin
        m_en = 0; m_ack = 0; m_evp = '0; m_exp32 = '0; m_exp8 = '0;
        for (int i = 0; i < 17; i++) begin
            m_cnt[i] = 0; m_sh[i] = 0; m_ovf32[i] = 0; m_ovf8[i] = 0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                m_en = 0; m_ack = 0; m_evp = '0;
                for (int i = 0; i < 17; i++) begin
                    m_cnt[i] = 0; m_sh[i] = 0; m_ovf32[i] = 0; m_ovf8[i] = 0;
                end
            end else begin
                bit req, wr_ctrl, wr_st, inc;
                req     = wb_cyc && wb_stb && !m_ack;
                wr_ctrl = req && wb_we && (wb_adr == 6'h00);
                wr_st   = req && wb_we && (wb_adr == 6'h01);
                if (req && !wb_we) begin
                    m_exp32 = model_read(wb_adr, 32);
                    m_exp8  = model_read(wb_adr, 8);
                end
                for (int i = 0; i < 17; i++) begin
                    inc = m_en && m_evp[i];
                    if (wr_ctrl && wb_dat_w[2]) m_sh[i] = m_cnt[i];
                    if (wr_ctrl && wb_dat_w[1]) begin
                        m_cnt[i] = 0; m_ovf32[i] = 0; m_ovf8[i] = 0;
                    end else begin
                        if (wr_st && wb_dat_w[i]) begin
                            m_ovf32[i] = 0; m_ovf8[i] = 0;
                        end
                        if (inc) begin
                            if (m_cnt[i] % 256 == 255) m_ovf8[i] = 1;
                            if (m_cnt[i] % 64'h1_0000_0000 == 64'hFFFF_FFFF) m_ovf32[i] = 1;
                            m_cnt[i]++;
                        end
                    end
                end
                if (wr_ctrl) m_en = wb_dat_w[0];
                m_evp = {ev, 1'b1};
                m_ack = req;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One bus transfer; lat is cycles from request to ack, 99 when no ack arrives.
    task automatic wb_xfer(input logic [5:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] r32, output logic [31:0] r8, output int lat);
        @(negedge clk);
        wb_adr = a; wb_we = we; wb_dat_w = d; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        lat = 99;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ack32) begin
                lat = k;
                break;
            end
        end
        r32 = dat_r32; r8 = dat_r8;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r32, r8;
        int lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_checks++; if (ack32 !== 1'b0 || ack8 !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b/%b want 0", ack32, ack8); end
        n_checks++; if (dat_r32 !== 32'd0 || err32 !== 1'b0 || err8 !== 1'b0) begin n_fail++; $display("FAIL reset_dat: got %h err %b/%b want 0", dat_r32, err32, err8); end
        wb_xfer(6'h02, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL id_latency: got %0d want 1", lat); end
        n_checks++; if (r32 !== 32'hABAC0001 || r8 !== 32'hABAC0001) begin n_fail++; $display("FAIL id_read: got %h/%h want abac0001", r32, r8); end
        wb_xfer(6'h20, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'd0 || r8 !== 32'd0) begin n_fail++; $display("FAIL shadow0_reset: got %h/%h want 0", r32, r8); end
        wb_xfer(6'h10, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'd0 || r32 !== m_exp32) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", r32); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        logic [3:0] pat;
        @(negedge clk);
        wb_adr = 6'h02; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pat[k] = ack32;
            if (ack32) acks++;
        end
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        n_checks++; if (pat !== 4'b0101 || acks != 2) begin n_fail++; $display("FAIL back_to_back: got ack pattern %b want 0101", pat); end
    endtask

    task automatic test_count();
        logic [31:0] r32, r8;
        int lat;
        int unsigned e_edge, s_edge;
        wb_xfer(6'h00, 1'b1, 32'd1, r32, r8, lat);
        e_edge = edge_n;
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL write_latency: got %0d want 1", lat); end
        ev_force = 16'h0020;
        repeat (5) @(negedge clk);
        ev_force = 16'h0000;
        repeat (20) @(negedge clk);
        wb_xfer(6'h00, 1'b1, 32'd5, r32, r8, lat);
        s_edge = edge_n;
        wb_xfer(6'h26, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'd5 || r8 !== 32'd5 || r32 !== m_exp32) begin n_fail++; $display("FAIL dcache_hit_count: got %0d/%0d want 5", r32, r8); end
        wb_xfer(6'h20, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'(s_edge - e_edge - 1)) begin n_fail++; $display("FAIL cycle_count: got %0d want %0d", r32, s_edge - e_edge - 1); end
        n_checks++; if (r32 !== m_exp32 || r8 !== m_exp8) begin n_fail++; $display("FAIL cycle_count_model: got %0d/%0d want %0d/%0d", r32, r8, m_exp32, m_exp8); end
        wb_xfer(6'h00, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'd1) begin n_fail++; $display("FAIL ctrl_readback: got %h want 1", r32); end
    endtask

    task automatic test_overflow();
        logic [31:0] r32, r8;
        int lat;
        wb_xfer(6'h00, 1'b1, 32'd3, r32, r8, lat);
        ev_force = 16'h0001;
        repeat (256) @(negedge clk);
        ev_force = 16'h0000;
        repeat (4) @(negedge clk);
        wb_xfer(6'h00, 1'b1, 32'd5, r32, r8, lat);
        wb_xfer(6'h21, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r8 !== 32'd0 || r32 !== 32'd256) begin n_fail++; $display("FAIL issued_wrap: got %0d/%0d want 256/0", r32, r8); end
        wb_xfer(6'h01, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r8[1] !== 1'b1 || r8 !== m_exp8 || r32 !== m_exp32) begin n_fail++; $display("FAIL status_ovf: got %h/%h want %h/%h", r32, r8, m_exp32, m_exp8); end
        wb_xfer(6'h01, 1'b1, 32'd2, r32, r8, lat);
        wb_xfer(6'h01, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r8[1] !== 1'b0 || r8 !== m_exp8) begin n_fail++; $display("FAIL status_w1c: got %h want %h", r8, m_exp8); end
    endtask

    task automatic test_clear();
        logic [31:0] r32, r8, pre;
        int lat;
        int unsigned c_edge, s_edge;
        ev_force = 16'h0004;
        repeat (6) @(negedge clk);
        wb_xfer(6'h00, 1'b1, 32'd5, r32, r8, lat);
        wb_xfer(6'h23, 1'b0, 32'd0, pre, r8, lat);
        n_checks++; if (pre !== m_exp32 || pre == 32'd0) begin n_fail++; $display("FAIL miss_pre: got %0d want %0d", pre, m_exp32); end
        wb_xfer(6'h00, 1'b1, 32'd3, r32, r8, lat);
        c_edge = edge_n;
        n_checks++; if (dut.live_all[3] !== 32'd0 || dut8.live_all[3] !== 8'd0) begin n_fail++; $display("FAIL live_clear: got %0d/%0d want 0", dut.live_all[3], dut8.live_all[3]); end
        wb_xfer(6'h23, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== pre || r32 !== m_exp32) begin n_fail++; $display("FAIL shadow_hold: got %0d want %0d", r32, pre); end
        repeat (7) @(negedge clk);
        wb_xfer(6'h00, 1'b1, 32'd5, r32, r8, lat);
        s_edge = edge_n;
        wb_xfer(6'h23, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'(s_edge - c_edge - 1) || r32 !== m_exp32) begin n_fail++; $display("FAIL miss_after_clear: got %0d want %0d", r32, s_edge - c_edge - 1); end
        ev_force = 16'h0000;
    endtask

    task automatic test_disable();
        logic [31:0] r32, r8;
        logic [31:0] first [17];
        int lat;
        rand_mode = 1'b1;
        repeat (10) @(negedge clk);
        wb_xfer(6'h00, 1'b1, 32'd0, r32, r8, lat);
        wb_xfer(6'h00, 1'b1, 32'd4, r32, r8, lat);
        for (int i = 0; i < 17; i++) begin
            wb_xfer(6'(32 + i), 1'b0, 32'd0, first[i], r8, lat);
            n_checks++; if (first[i] !== m_exp32 || r8 !== m_exp8) begin n_fail++; $display("FAIL disabled_snap1[%0d]: got %0d/%0d want %0d/%0d", i, first[i], r8, m_exp32, m_exp8); end
        end
        repeat (10) @(negedge clk);
        wb_xfer(6'h00, 1'b1, 32'd4, r32, r8, lat);
        for (int i = 0; i < 17; i++) begin
            wb_xfer(6'(32 + i), 1'b0, 32'd0, r32, r8, lat);
            n_checks++; if (r32 !== first[i] || r32 !== m_exp32) begin n_fail++; $display("FAIL disabled_snap2[%0d]: got %0d want %0d", i, r32, first[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] r32, r8;
        int lat;
        logic [5:0] a;
        wb_xfer(6'h00, 1'b1, 32'd3, r32, r8, lat);
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(60, 3)) @(negedge clk);
            if ($urandom_range(1, 0) == 1) wb_xfer(6'h01, 1'b1, 32'($urandom_range(32'h1FFFF, 0)), r32, r8, lat);
            wb_xfer(6'h00, 1'b1, 32'd5 | 32'($urandom_range(1, 0) << 1), r32, r8, lat);
            wb_xfer(6'h01, 1'b0, 32'd0, r32, r8, lat);
            n_checks++; if (r32 !== m_exp32 || r8 !== m_exp8) begin n_fail++; $display("FAIL rand_status[%0d]: got %h/%h want %h/%h", n, r32, r8, m_exp32, m_exp8); end
            a = 6'(32 + $urandom_range(16, 0));
            wb_xfer(a, 1'b0, 32'd0, r32, r8, lat);
            n_checks++; if (r32 !== m_exp32 || r8 !== m_exp8) begin n_fail++; $display("FAIL rand_shadow[%h]: got %0d/%0d want %0d/%0d", a, r32, r8, m_exp32, m_exp8); end
        end
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] r32, r8;
        int lat;
        @(negedge clk);
        wb_adr = 6'h20; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ack32 !== 1'b0 || ack8 !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ack: got %b/%b want 0", ack32, ack8); end
        wb_cyc = 1'b0; wb_stb = 1'b0; rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wb_xfer(6'(32 + i), 1'b0, 32'd0, r32, r8, lat);
            n_checks++; if (r32 !== 32'd0 || r8 !== 32'd0) begin n_fail++; $display("FAIL post_reset_shadow[%0d]: got %0d/%0d want 0", i, r32, r8); end
        end
        wb_xfer(6'h00, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'd0 || r8 !== 32'd0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h/%h want 0", r32, r8); end
        wb_xfer(6'h01, 1'b0, 32'd0, r32, r8, lat);
        n_checks++; if (r32 !== 32'd0 || r8 !== 32'd0) begin n_fail++; $display("FAIL post_reset_status: got %h/%h want 0", r32, r8); end
    endtask

    initial begin
        rst = 1'b1; rand_mode = 1'b0; ev_force = '0;
        wb_adr = '0; wb_dat_w = '0; wb_sel = 4'hF; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        test_reset();
        test_back_to_back();
        test_count();
        test_overflow();
        test_clear();
        test_disable();
        test_random();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/abacus_perf_counters.md
Name: abacus_perf_counters

Overview:
- Wishbone-readable bank of event counters consuming the ABACUS profiling outputs of the CVA5 LiteX wrapper: instruction issue, cache, branch and issue-stall events.
- Sits directly downstream of the core wrapper on the LiteX CSR/peripheral Wishbone bus.
- Counts per-cycle events while enabled.
- Software takes an atomic snapshot of all counters into shadow registers, then reads the shadows.

Parameters:
- COUNTER_W, 32, width of each counter; legal range 8..32; reads zero-extend to 32 bits.
- NUM_COUNTERS, 17, fixed by the package event map; not overridable.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- abacus_instruction_issued, abacus_icache_request, abacus_icache_miss, abacus_icache_line_fill_in_progress, abacus_dcache_request, abacus_dcache_hit, abacus_dcache_line_fill_in_progress, abacus_branch_misprediction, abacus_ras_misprediction, abacus_issue_no_instruction_stat, abacus_issue_no_id_stat, abacus_issue_flush_stat, abacus_unit_busy_stat, abacus_issue_operands_not_ready_stat, abacus_issue_hold_stat, abacus_issue_multi_source_stat  in  1 each  event strobes, level per cycle
- wb_adr  in  6  word address
- wb_dat_w  in  32  write data
- wb_sel  in  4  byte select; ignored, all writes are full-word
- wb_cyc, wb_stb, wb_we  in  1  Wishbone classic controls
- wb_dat_r  out  32  read data
- wb_ack  out  1  transfer acknowledge
- wb_err  out  1  tied 0

Behaviour:
- Reset: all live counters, shadows, overflow flags and event pipeline registers = 0; CTRL.enable = 0; wb_ack = 0; wb_dat_r = 0. Reset mid-transfer drops ack; the master must retry.
- Event map, index i:
  - 0: cycle, constant 1
  - 1: issued
  - 2: icache_request
  - 3: icache_miss
  - 4: icache_fill
  - 5: dcache_request
  - 6: dcache_hit
  - 7: dcache_fill
  - 8: branch_mispred
  - 9: ras_mispred
  - 10: no_instruction
  - 11: no_id
  - 12: flush
  - 13: unit_busy
  - 14: operands_not_ready
  - 15: hold
  - 16: multi_source
- Pipeline: event inputs are registered once. An event high in cycle t appears in the live counter after edge t+2.
- Increment: live[i] += 1 when enable && event_q[i].
  - Wrap 2^COUNTER_W-1 -> 0, which sets sticky ovf[i].
- Register map (word addresses):
  - 0x00 CTRL: bit0 enable RW; bit1 clear, write-1 pulse, reads 0; bit2 snapshot, write-1 pulse, reads 0.
  - 0x01 STATUS: bits[16:0] ovf, write-1-to-clear.
  - 0x02 ID: constant 32'hABAC_0001.
  - 0x20+i, i=0..16: shadow[i], read-only.
  - Unmapped or read-only writes: ignored. Unmapped reads: return 0.
- Wishbone handshake:
  - Request in cycle t (cyc && stb && !ack) -> ack = 1 in cycle t+1 for exactly one cycle.
  - wb_dat_r is valid in the ack cycle.
  - Back-to-back requests are acked every other cycle.
  - cyc dropped before ack: the registered ack still asserts once and the master ignores it.
- Control effect: write side effects apply at the edge ending cycle t, the same edge that raises ack.
- Simultaneous events:
  - clear + increment: clear wins; live = 0 and ovf = 0. Event_q at that edge is dropped. Shadows are untouched.
  - snapshot + increment: shadow gets the pre-increment value; live still increments.
  - clear + snapshot in one write: shadow gets the pre-clear value, then live = 0.
  - wrap + STATUS W1C on the same bit: the set wins, so ovf stays 1.
  - enable = 0: counters hold; event_q keeps sampling.

Decomposition:
- Package abacus_perf_pkg holds:
  - event index enum and NUM_EVENTS = 17
  - address constants CTRL_ADDR, STATUS_ADDR, ID_ADDR, SHADOW_BASE
  - CTRL bit positions
  - ID_VALUE
- Sub-module abacus_counter: one counter.
  - Inputs: clk, rst, inc, clear, snapshot.
  - Outputs: live, shadow, wrap pulse.
  - Instantiated NUM_EVENTS times in a generate loop.
- The top level holds the event registers, CTRL/STATUS and Wishbone decode.

Test Plan:
- Reset, then read 0x02 and 0x20 -> 32'hABAC0001; 0. Ack asserts exactly 1 cycle after the request.
- Write CTRL=1; pulse dcache_hit for 5 cycles; 20 idle cycles; write CTRL=5 (snapshot); read 0x26 -> 5. Read 0x20 -> the cycles elapsed from the enable edge to the snapshot edge, computed by the scoreboard.
- COUNTER_W=8, enable, hold issued high 256 cycles, snapshot -> shadow[1]=0 and STATUS bit1=1. Write STATUS=2 -> STATUS reads 0.
- Hold icache_miss high, write CTRL=3 (enable+clear) -> after the ack edge, live[3]=0 and the next snapshot equals cycles since clear minus pipeline offset. Shadow[3] is unchanged until the snapshot.
- Write CTRL=0 with events active; snapshot twice 10 cycles apart -> identical shadow values.
- Assert rst mid-read (cyc/stb high) -> ack=0 next cycle. All shadows read 0 after reset; CTRL reads 0.
